// File: rtl/bench_result_log.sv
// rtl/bench_result_log.sv - FIFO of benchmark result records, drained one 32-bit word per read request.
// Each record is four condition timers plus a meta word; records arriving while full are counted and dropped.
module bench_result_log #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done,
  input  logic [31:0]              t_cond0,
  input  logic [31:0]              t_cond1,
  input  logic [31:0]              t_cond2,
  input  logic [31:0]              t_cond3,
  input  logic [1:0]               winner_code,
  input  logic [3:0]               led_onehot,
  input  logic                     clear,
  input  logic                     rd_req,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic                     rd_last,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         overflow_cnt,
  output logic [CNT_W-1:0]         seq_next
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2:0]         word_idx_q, word_idx_d;
  logic [CNT_W-1:0]   ovf_q, ovf_d;
  logic [CNT_W-1:0]   seq_q, seq_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;

  logic [4:0][31:0]   mem_q [DEPTH];

  logic               is_empty, is_full, capture, drop, rd_hit, pop;
  logic [15:0]        meta_seq;
  logic [4:0][31:0]   wr_rec;

  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == CW'(DEPTH));
    capture  = done && !is_full && !clear;
    drop     = done && is_full && !clear;
    rd_hit   = rd_req && !is_empty && !clear;
    pop      = rd_hit && (word_idx_q == 3'd4);
    meta_seq = 16'(seq_q);
    wr_rec   = {{meta_seq, 8'h00, led_onehot, 2'b00, winner_code},
                t_cond3, t_cond2, t_cond1, t_cond0};
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    ovf_d      = ovf_q;
    seq_d      = seq_q + CNT_W'(done);
    rd_valid_d = rd_req;
    rd_data_d  = '0;
    rd_last_d  = 1'b0;

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      word_idx_d = '0;
      ovf_d      = '0;
    end else begin
      if (rd_hit) begin
        rd_data_d = mem_q[rd_ptr_q][word_idx_q];
        rd_last_d = pop;
        if (pop) begin
          rd_ptr_d   = rd_ptr_q + PW'(1);
          word_idx_d = '0;
        end else begin
          word_idx_d = word_idx_q + 3'd1;
        end
      end
      if (capture) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      // Full is judged on the registered count, so a same-cycle pop does not rescue the record.
      if (drop && (ovf_q != '1)) begin
        ovf_d = ovf_q + CNT_W'(1);
      end
      count_d = count_q + CW'(capture) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      ovf_q      <= '0;
      seq_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      ovf_q      <= ovf_d;
      seq_q      <= seq_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (capture) begin
      mem_q[wr_ptr_q] <= wr_rec;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_last      = rd_last_q;
  assign empty        = is_empty;
  assign full         = is_full;
  assign count        = count_q;
  assign overflow_cnt = ovf_q;
  assign seq_next     = seq_q;

endmodule
